// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: en/clr for the four inter-stage buffers plus PC enable.
// Optional event counters are compiled in when PIPE_CTRL_STATS_EN is defined.
module pipe_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_r1_pos,
  input  logic [4:0]  id_r2_pos,
  input  logic        id_r1_used,
  input  logic        id_r2_used,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_dst,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        wb_halt,
  input  logic        resume,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_clr,
  output logic        idex_en,
  output logic        idex_clr,
  output logic        exmem_en,
  output logic        exmem_clr,
  output logic        memwb_en,
  output logic        memwb_clr,
`ifdef PIPE_CTRL_STATS_EN
  output logic [31:0] stat_cycles,
  output logic [31:0] stat_stalls,
  output logic [31:0] stat_flushes,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  // WAIT lasts MEM_LAT-2 cycles; the RUN cycle that sees mem_req is the first frozen one.
  localparam int         WLOAD_I = (MEM_LAT > 2) ? MEM_LAT - 2 : 0;
  localparam logic [3:0] WLOAD   = WLOAD_I[3:0];

  state_t     state_q;
  logic [3:0] wcnt_q;
  logic       mem_done_q;
  logic       halted_q;

  logic load_use;
  logic mem_start;
  logic mem_stall;
  logic active;
  logic br_eff;
  logic lu_eff;

  assign load_use  = ex_is_load && (ex_dst != 5'd0) &&
                     ((id_r1_used && (id_r1_pos == ex_dst)) ||
                      (id_r2_used && (id_r2_pos == ex_dst)));
  assign mem_start = (state_q == RUN) && mem_req && (MEM_LAT > 1) && !mem_done_q;
  assign mem_stall = (state_q == WAIT) || mem_start;
  assign active    = (state_q != HALT);
  assign br_eff    = active && !mem_stall && ex_branch_taken;
  assign lu_eff    = active && !mem_stall && !ex_branch_taken && load_use;
  assign halted    = halted_q;

  always_comb begin
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    ifid_clr  = 1'b0;
    idex_en   = 1'b0;
    idex_clr  = 1'b0;
    exmem_en  = 1'b0;
    exmem_clr = 1'b0;
    memwb_en  = 1'b0;
    memwb_clr = 1'b0;
    if (rst_n && active) begin
      if (mem_stall) begin
        memwb_en  = 1'b1;
        memwb_clr = 1'b1;
      end else if (br_eff) begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_clr = 1'b1;
        idex_en  = 1'b1;
        idex_clr = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end else if (lu_eff) begin
        idex_en  = 1'b1;
        idex_clr = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wcnt_q     <= 4'd0;
      mem_done_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      mem_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (wb_halt) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (mem_start) begin
            // A two-cycle access needs no WAIT: the next RUN cycle already advances.
            if (MEM_LAT == 2) begin
              mem_done_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              wcnt_q  <= WLOAD;
            end
          end
        end
        WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_q    <= RUN;
            mem_done_q <= 1'b1;
          end
        end
        HALT: begin
          if (resume) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stat_cycles_q;
  logic [31:0] stat_stalls_q;
  logic [31:0] stat_flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cycles_q  <= 32'd0;
      stat_stalls_q  <= 32'd0;
      stat_flushes_q <= 32'd0;
    end else begin
      if (active)
        stat_cycles_q <= stat_cycles_q + 32'd1;
      if ((state_q == WAIT) || lu_eff)
        stat_stalls_q <= stat_stalls_q + 32'd1;
      if (br_eff)
        stat_flushes_q <= stat_flushes_q + 32'd1;
    end
  end

  assign stat_cycles  = stat_cycles_q;
  assign stat_stalls  = stat_stalls_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: three instances (MEM_LAT 1, 3, 4) share stimulus and are
// compared every cycle against an access-level model, plus literal spot checks.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_r1_pos, id_r2_pos, ex_dst;
  logic       id_r1_used, id_r2_used, ex_is_load, ex_branch_taken;
  logic       mem_req, wb_halt, resume;

  // Bit order: pc_en ifid_en ifid_clr idex_en idex_clr exmem_en exmem_clr memwb_en memwb_clr halted
  wire [2:0][9:0]  o;
  wire [2:0][31:0] st_cyc, st_stl, st_fl;

  localparam logic [9:0] V_HALT  = 10'b0000000001;
  localparam logic [9:0] V_STALL = 10'b0000000110;
  localparam logic [9:0] V_BR    = 10'b1111110100;
  localparam logic [9:0] V_LU    = 10'b0001110100;
  localparam logic [9:0] V_NORM  = 10'b1101010100;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    pipe_ctrl #(.MEM_LAT(gi == 0 ? 1 : (gi == 1 ? 3 : 4))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .id_r1_pos(id_r1_pos), .id_r2_pos(id_r2_pos),
      .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
      .ex_is_load(ex_is_load), .ex_dst(ex_dst),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
      .wb_halt(wb_halt), .resume(resume),
      .pc_en(o[gi][9]), .ifid_en(o[gi][8]), .ifid_clr(o[gi][7]),
      .idex_en(o[gi][6]), .idex_clr(o[gi][5]),
      .exmem_en(o[gi][4]), .exmem_clr(o[gi][3]),
      .memwb_en(o[gi][2]), .memwb_clr(o[gi][1]),
`ifdef PIPE_CTRL_STATS_EN
      .stat_cycles(st_cyc[gi]), .stat_stalls(st_stl[gi]), .stat_flushes(st_fl[gi]),
`endif
      .halted(o[gi][0])
    );
  end

`ifndef PIPE_CTRL_STATS_EN
  assign st_cyc = '0;
  assign st_stl = '0;
  assign st_fl  = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: per instance, whether halted, how many frozen cycles of the current
  // memory access still remain after this one, and whether an access just finished.
  bit     m_halt [3];
  int     m_left [3];
  bit     m_done [3];
  int     m_cyc  [3];
  int     m_stl  [3];
  int     m_fl   [3];

  always @(negedge clk) begin
    logic [9:0] e;
    bit lu, stall_now;
    lu = ex_is_load && (ex_dst != 0) &&
         ((id_r1_used && id_r1_pos == ex_dst) || (id_r2_used && id_r2_pos == ex_dst));
    for (int k = 0; k < 3; k++) begin
      stall_now = (m_left[k] > 0) || (mem_req && lat_of(k) > 1 && !m_done[k]);
      if (!rst_n)               e = 10'd0;
      else if (m_halt[k])       e = V_HALT;
      else if (stall_now)       e = V_STALL;
      else if (ex_branch_taken) e = V_BR;
      else if (lu)              e = V_LU;
      else                      e = V_NORM;
      check($sformatf("cycle_outputs_lat%0d", lat_of(k)), 32'(o[k]), 32'(e));
`ifdef PIPE_CTRL_STATS_EN
      check($sformatf("stat_cycles_lat%0d", lat_of(k)), st_cyc[k], m_cyc[k]);
      check($sformatf("stat_stalls_lat%0d", lat_of(k)), st_stl[k], m_stl[k]);
      check($sformatf("stat_flushes_lat%0d", lat_of(k)), st_fl[k], m_fl[k]);
`endif
      if (!rst_n) begin
        m_halt[k] = 0; m_left[k] = 0; m_done[k] = 0;
        m_cyc[k] = 0; m_stl[k] = 0; m_fl[k] = 0;
      end else if (m_halt[k]) begin
        m_done[k] = 0;
        if (resume) m_halt[k] = 0;
      end else begin
        m_cyc[k]++;
        if (m_left[k] > 0 || (!stall_now && !ex_branch_taken && lu)) m_stl[k]++;
        if (!stall_now && ex_branch_taken) m_fl[k]++;
        if (m_left[k] > 0) begin
          m_left[k]--;
          m_done[k] = (m_left[k] == 0);
        end else if (wb_halt) begin
          m_halt[k] = 1; m_done[k] = 0;
        end else if (stall_now) begin
          m_left[k] = lat_of(k) - 2;
          m_done[k] = (m_left[k] == 0);
        end else begin
          m_done[k] = 0;
        end
      end
    end
  end

  task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic ld, input logic [4:0] dst, input logic br, input logic mr,
                       input logic hl, input logic rs);
    id_r1_pos = r1; id_r1_used = u1; id_r2_pos = r2; id_r2_used = u2;
    ex_is_load = ld; ex_dst = dst; ex_branch_taken = br; mem_req = mr;
    wb_halt = hl; resume = rs;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int k, input logic [9:0] exp);
    #1;
    check(name, 32'(o[k]), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    check("reset_outputs_lat1", 32'(o[0]), 32'd0);
    check("reset_outputs_lat4", 32'(o[2]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    lit("idle_after_reset", 0, V_NORM);

    tick(); drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("load_use_r1", 0, V_LU);
    tick(); drive(5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("load_dst_zero", 0, V_NORM);
    tick(); drive(5'd3, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("load_use_r2", 0, V_LU);
    tick(); drive(5'd3, 1'b1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("load_r2_unused", 0, V_NORM);
    tick(); drive(5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("branch_over_load_use", 0, V_BR);
    tick(); drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    lit("branch_alone", 0, V_BR);

    tick(); drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      lit($sformatf("mem_lat3_c%0d", i), 1, (i % 3 == 2) ? V_NORM : V_STALL);
      check($sformatf("mem_lat4_c%0d", i), 32'(o[2]), 32'((i % 4 == 3) ? V_NORM : V_STALL));
      check($sformatf("mem_lat1_c%0d", i), 32'(o[0]), 32'(V_NORM));
      tick();
    end
    idle();
    repeat (4) tick();

    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    lit("halt_request_cycle", 0, V_NORM);
    tick(); drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    lit("halted_next_cycle", 0, V_HALT);
    tick(); drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    lit("resume_cycle_still_halted", 0, V_HALT);
    tick(); idle();
    lit("after_resume", 0, V_NORM);

    tick(); drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("lat4_first_frozen", 2, V_STALL);
    tick(); idle();
    lit("lat4_wait_cycle1", 2, V_STALL);
    #1 rst_n = 1'b0;
    lit("reset_mid_wait_lat4", 2, 10'd0);
    check("reset_mid_wait_lat3", 32'(o[1]), 32'd0);
    tick();
    rst_n = 1'b1;
    lit("run_after_reset_lat4", 2, V_NORM);
    check("run_after_reset_lat3", 32'(o[1]), 32'(V_NORM));

`ifdef PIPE_CTRL_STATS_EN
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3)      drive(5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (i == 6) drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      else             idle();
      tick();
    end
    idle();
    #1;
    check("stats_cycles_10", st_cyc[0], 32'd10);
    check("stats_stalls_1", st_stl[0], 32'd1);
    check("stats_flushes_1", st_fl[0], 32'd1);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage CPU. It generates the `en`/`clr` pair for each of the four inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC write enable. It resolves load-use stalls, taken-branch flushes, multi-cycle memory waits and program halt. It sits beside the datapath and takes hazard information from the ID, EX, MEM and WB stages.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles a load/store occupies MEM (1..15).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_r1_pos`, `id_r2_pos` in 5: source register numbers of the instruction in ID.
- `id_r1_used`, `id_r2_used` in 1: the ID instruction reads that source.
- `ex_is_load` in 1: the EX instruction is a load.
- `ex_dst` in 5: destination register of the EX instruction.
- `ex_branch_taken` in 1: branch or jump resolved taken in EX.
- `mem_req` in 1: the MEM instruction is a load or store.
- `wb_halt` in 1: a halt syscall is in WB.
- `resume` in 1: leave the HALT state.
- `pc_en` out 1: PC write enable.
- `ifid_en`, `ifid_clr`, `idex_en`, `idex_clr`, `exmem_en`, `exmem_clr`, `memwb_en`, `memwb_clr` out 1: buffer controls.
- `halted` out 1: the controller is in HALT.

## Operation
- FSM states: RUN (reset state), WAIT, HALT. A 4-bit down-counter `wcnt` resets to 0.
- Buffers honour `clr` only when `en`=1. A bubble is therefore `en`=1, `clr`=1.
- Output priority, highest first:
  1. `rst_n`=0: all outputs 0.
  2. HALT: all enables 0, all clears 0, `halted`=1.
  3. MEM wait, which is state WAIT, or RUN with `mem_req`=1 and `MEM_LAT`>1: `pc_en`, `ifid_en`, `idex_en` and `exmem_en` are 0; `memwb_en`=1 and `memwb_clr`=1.
  4. Branch, i.e. `ex_branch_taken`=1: all enables 1; `ifid_clr`=1 and `idex_clr`=1.
  5. Load-use, i.e. `ex_is_load`=1, `ex_dst`≠0, and `ex_dst` equals a used ID source: `pc_en`=0, `ifid_en`=0, `idex_en`=1, `idex_clr`=1, and the remaining enables are 1.
  6. Otherwise: all enables 1, all clears 0.
- Branch and load-use in the same cycle resolve as branch. The dependent instruction sits in ID and is flushed.
- `wb_halt` is evaluated only in RUN and has priority over entering WAIT. The halting instruction is in WB and retires this cycle.
- Transitions:
  - RUN→HALT on `wb_halt`.
  - RUN→WAIT on `mem_req` with `MEM_LAT`>1, setting `wcnt` = `MEM_LAT`-2.
  - WAIT: `wcnt` decrements each cycle. When `wcnt`=0 the next state is RUN.
  - In the first RUN cycle after WAIT, the MEM instruction advances normally and `mem_req` for that same instruction is ignored. A one-cycle `mem_done` flag implements this.
  - HALT→RUN on `resume`. `wb_halt` is ignored while in HALT.
- With `MEM_LAT`=1, WAIT is unreachable.

## Timing
- All outputs except `halted` are combinational from state and inputs, with zero latency. `halted` is registered.
- A memory access holds MEM for exactly `MEM_LAT` cycles: `MEM_LAT`-1 frozen cycles, then 1 advancing cycle.
- A load-use stall costs 1 cycle. A taken branch costs 2 flushed slots.
- Asserting `rst_n` low at any point, including mid-WAIT, immediately forces RUN, `wcnt`=0, `mem_done`=0, `halted`=0 and all outputs 0.

## Configuration
- `PIPE_CTRL_STATS_EN`: when defined, the block adds three 32-bit counters, each reset to 0 and wrapping modulo 2^32:
  - `stat_cycles` counts every cycle not in HALT.
  - `stat_stalls` counts load-use stall cycles and WAIT cycles.
  - `stat_flushes` counts taken-branch cycles.
- When defined, the block also adds the three 32-bit output ports `stat_cycles`, `stat_stalls` and `stat_flushes`.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

## Test plan
- Load-use: `ex_is_load`=1, `ex_dst`=5, `id_r1_pos`=5, `id_r1_used`=1 -> `pc_en`=0, `ifid_en`=0, `idex_clr`=1, `memwb_en`=1. With `ex_dst`=0 instead -> no stall.
- Branch plus load-use in the same cycle -> `ifid_clr`=`idex_clr`=1, `pc_en`=1, no stall.
- `MEM_LAT`=3, `mem_req` held at 1 -> 2 frozen cycles with `memwb_clr`=1, then 1 normal cycle; with `mem_req` continuously 1, the sequence repeats with period 3.
- `wb_halt` pulse -> `halted`=1 from the next cycle with all enables 0; `resume` -> `halted`=0 the following cycle.
- `rst_n` low during WAIT cycle 1 of `MEM_LAT`=4 -> outputs 0 immediately; after release, state is RUN and `mem_req`=0 gives all enables 1.
- With `PIPE_CTRL_STATS_EN`: 10 cycles containing 1 load-use and 1 branch -> `stat_cycles`=10, `stat_stalls`=1, `stat_flushes`=1.
